// File: rtl/vga_pattern_scheduler.sv
// VGA raster timing plus test-pattern sequencer.
// The block generates the raster counters and the sync and blanking signals.
// It also chooses the active test pattern. A new pattern is selected either by
// a button request or by the auto-cycle frame counter. The selection only
// changes at the frame boundary, so each frame shows a single pattern.
module vga_pattern_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int NUM_PATTERNS = 4,
  parameter int AUTO_FRAMES  = 60,
  localparam int PW          = $clog2(NUM_PATTERNS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn_next,
  input  logic          auto_en,
  output logic [9:0]    hpos,
  output logic [9:0]    vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          frame_start,
  output logic [PW-1:0] pattern_sel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FCW     = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [9:0]     H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]     V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]     H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0]     V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0]     H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]     H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]     V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]     V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0]  SEL_LAST   = PW'(NUM_PATTERNS - 1);
  localparam logic [FCW-1:0] CNT_LAST   = FCW'(AUTO_FRAMES - 1);

  logic           h_wrap, fb;
  logic           btn_s1, btn_s2, btn_prev, btn_edge;
  logic           auto_s1, auto_s2;
  logic           pending, auto_hit, advance;
  logic [FCW-1:0] frame_cnt;

  assign h_wrap   = (hpos == H_LAST);
  assign fb       = h_wrap && (vpos == V_LAST);
  assign btn_edge = btn_s2 && !btn_prev;
  assign auto_hit = auto_s2 && (frame_cnt == CNT_LAST);
  assign advance  = fb && (pending || auto_hit);

  // Raster counters: hpos every clock, vpos on each line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else begin
      hpos <= h_wrap ? '0 : hpos + 10'd1;
      if (h_wrap) vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
    end
  end

  // Sync and blanking are decoded from the registered counters with zero latency.
  always_comb begin
    hsync      = !((hpos >= H_SYNC_ON) && (hpos < H_SYNC_OFF));
    vsync      = !((vpos >= V_SYNC_ON) && (vpos < V_SYNC_OFF));
    display_on = (hpos < H_VIS) && (vpos < V_VIS);
  end

  // Two-flop synchronizers. btn_prev provides the rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
      auto_s1  <= 1'b0;
      auto_s2  <= 1'b0;
    end else begin
      btn_s1   <= btn_next;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      auto_s1  <= auto_en;
      auto_s2  <= auto_s1;
    end
  end

  // Frame control: the frame_start pulse, the auto frame counter, the pending request and the pattern select.
  // A button edge that lands on the boundary cycle is kept in pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      pending     <= 1'b0;
      pattern_sel <= '0;
    end else begin
      frame_start <= fb;

      if (!auto_s2)   frame_cnt <= '0;
      else if (fb)    frame_cnt <= auto_hit ? '0 : frame_cnt + FCW'(1);

      if (fb)         pending <= btn_edge;
      else if (btn_edge) pending <= 1'b1;

      if (advance)
        pattern_sel <= (pattern_sel == SEL_LAST) ? '0 : pattern_sel + PW'(1);
    end
  end

endmodule
